// File: rtl/xspi_slave_responder_if.sv
// Pad-side and memory-side signal bundle of the xSPI 8S-8S-8S target responder.
// The slave modport is the responder's view; the master modport is the link/memory side.
interface xspi_slave_responder_if;
  logic        cs_n;
  logic [7:0]  dq_in;
  logic [7:0]  dq_out;
  logic        dq_oe;
  logic [47:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_wr_en;
  logic        mem_rd_en;
  logic [63:0] mem_rdata;
  logic        done;
  logic        crc_ca_match;
  logic        crc_ca_error;
  logic        crc_data_match;
  logic        crc_data_error;
  logic [7:0]  nack_count;

  modport slave (
    input  cs_n, dq_in, mem_rdata,
    output dq_out, dq_oe, mem_addr, mem_wdata, mem_wr_en, mem_rd_en, done,
           crc_ca_match, crc_ca_error, crc_data_match, crc_data_error, nack_count
  );

  modport master (
    output cs_n, dq_in, mem_rdata,
    input  dq_out, dq_oe, mem_addr, mem_wdata, mem_wr_en, mem_rd_en, done,
           crc_ca_match, crc_ca_error, crc_data_match, crc_data_error, nack_count
  );
endinterface

// File: rtl/xspi_slave_responder.sv
// xSPI 8S-8S-8S target responder: decodes CA frames a byte per clk, checks CA and write-data
// CRC-8, answers with an ACK/NACK/ILL status byte and returns CRC-protected read data.
module xspi_slave_responder #(
  parameter int unsigned TURN_CYCLES = 4,
  parameter logic [7:0]  CMD_WRITE   = 8'hA5,
  parameter logic [7:0]  CMD_READ    = 8'hFF,
  parameter logic [7:0]  ACK_BYTE    = 8'hAC,
  parameter logic [7:0]  NACK_BYTE   = 8'hEE,
  parameter logic [7:0]  ILL_BYTE    = 8'hE1
) (
  input logic                   clk,
  input logic                   rst,
  xspi_slave_responder_if.slave bus
);
  typedef enum logic [3:0] {
    IDLE, ADDR, CA_CRC, WDATA, WCRC, TURN, STATUS, RDATA, RCRC, WAIT_CS
  } state_t;

  localparam logic [3:0] TURN_LAST = 4'(TURN_CYCLES - 32'd1);

  function automatic logic [7:0] crc8_byte(input logic [7:0] crc_in, input logic [7:0] data);
    logic [7:0] c;
    c = crc_in ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

  function automatic logic [7:0] crc8_word(input logic [63:0] word);
    logic [7:0]  c;
    logic [63:0] w;
    c = 8'h00;
    w = word;
    for (int i = 0; i < 8; i++) begin
      c = crc8_byte(c, w[63:56]);
      w = {w[55:0], 8'h00};
    end
    return c;
  endfunction

  state_t      state_r, state_s;
  logic [3:0]  cnt_r, cnt_s;
  logic [7:0]  resp_r, resp_s;
  logic [7:0]  cmd_r, crc_r;
  logic [47:0] addr_sh_r;
  logic [63:0] wdata_sh_r, rd_sh_r;
  logic [7:0]  rd_crc_r;
  logic        rd_cap_r;
  logic [7:0]  dq_out_r, dq_out_s, nack_count_r;
  logic [47:0] mem_addr_r;
  logic [63:0] mem_wdata_r;
  logic        dq_oe_r, dq_oe_s, wr_en_r, wr_en_s, rd_en_r, rd_en_s, done_r, done_s;
  logic        ca_match_r, ca_match_s, ca_error_r, ca_error_s;
  logic        d_match_r, d_match_s, d_error_r, d_error_s;
  logic        latch_addr_s, latch_wdata_s, nack_inc_s;

  // Next-state and next-output decode; every output is registered from these values.
  always_comb begin
    state_s = state_r; cnt_s = cnt_r; resp_s = resp_r;
    dq_out_s = 8'h00; dq_oe_s = 1'b0; wr_en_s = 1'b0; rd_en_s = 1'b0; done_s = 1'b0;
    ca_match_s = 1'b0; ca_error_s = 1'b0; d_match_s = 1'b0; d_error_s = 1'b0;
    latch_addr_s = 1'b0; latch_wdata_s = 1'b0; nack_inc_s = 1'b0;
    if (bus.cs_n && state_r != IDLE && state_r != WAIT_CS) begin
      state_s = IDLE;
      cnt_s   = 4'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (!bus.cs_n) begin state_s = ADDR; cnt_s = 4'd0; end
          else begin state_s = IDLE; end
        end
        ADDR: begin
          if (cnt_r == 4'd5) begin state_s = CA_CRC; cnt_s = 4'd0; end
          else begin cnt_s = cnt_r + 4'd1; end
        end
        CA_CRC: begin
          cnt_s = 4'd0;
          if (bus.dq_in == crc_r) begin
            ca_match_s   = 1'b1;
            latch_addr_s = 1'b1;
            if (cmd_r == CMD_WRITE) begin
              state_s = WDATA;
            end else if (cmd_r == CMD_READ) begin
              state_s = TURN; rd_en_s = 1'b1; resp_s = ACK_BYTE;
            end else begin
              state_s = TURN; resp_s = ILL_BYTE;
            end
          end else begin
            ca_error_s = 1'b1; state_s = TURN; resp_s = NACK_BYTE;
          end
        end
        WDATA: begin
          if (cnt_r == 4'd7) begin state_s = WCRC; cnt_s = 4'd0; end
          else begin cnt_s = cnt_r + 4'd1; end
        end
        WCRC: begin
          state_s = TURN;
          cnt_s   = 4'd0;
          if (bus.dq_in == crc_r) begin
            d_match_s = 1'b1; latch_wdata_s = 1'b1; resp_s = ACK_BYTE;
          end else begin
            d_error_s = 1'b1; resp_s = NACK_BYTE;
          end
        end
        TURN: begin
          if (cnt_r == TURN_LAST) begin
            state_s    = STATUS;
            cnt_s      = 4'd0;
            dq_oe_s    = 1'b1;
            dq_out_s   = resp_r;
            wr_en_s    = (cmd_r == CMD_WRITE) && (resp_r == ACK_BYTE);
            nack_inc_s = (resp_r == NACK_BYTE);
          end else begin
            cnt_s = cnt_r + 4'd1;
          end
        end
        STATUS: begin
          if (cmd_r == CMD_READ && resp_r == ACK_BYTE) begin
            state_s = RDATA; cnt_s = 4'd0; dq_oe_s = 1'b1; dq_out_s = rd_sh_r[63:56];
          end else begin
            state_s = WAIT_CS; done_s = 1'b1;
          end
        end
        RDATA: begin
          dq_oe_s = 1'b1;
          if (cnt_r == 4'd7) begin
            state_s = RCRC; dq_out_s = rd_crc_r;
          end else begin
            cnt_s = cnt_r + 4'd1; dq_out_s = rd_sh_r[63:56];
          end
        end
        RCRC: begin
          state_s = WAIT_CS; done_s = 1'b1;
        end
        WAIT_CS: begin
          if (bus.cs_n) begin state_s = IDLE; end
          else begin state_s = WAIT_CS; end
        end
        default: begin
          state_s = IDLE; cnt_s = 4'd0;
        end
      endcase
    end
  end

  // State, counter and pending-status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      resp_r  <= 8'h00;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      resp_r  <= resp_s;
    end
  end

  // Frame datapath: command, running CRC, address/data shifters and read-data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_r <= 8'h00; crc_r <= 8'h00; addr_sh_r <= 48'h0; wdata_sh_r <= 64'h0;
      rd_sh_r <= 64'h0; rd_crc_r <= 8'h00; rd_cap_r <= 1'b0;
    end else begin
      rd_cap_r <= rd_en_r;
      if (rd_cap_r) begin
        rd_sh_r  <= bus.mem_rdata;
        rd_crc_r <= crc8_word(bus.mem_rdata);
      end else if (state_s == RDATA) begin
        rd_sh_r <= {rd_sh_r[55:0], 8'h00};
      end
      case (state_r)
        IDLE:   if (!bus.cs_n) begin cmd_r <= bus.dq_in; crc_r <= crc8_byte(8'h00, bus.dq_in); end
        ADDR:   if (!bus.cs_n) begin addr_sh_r <= {addr_sh_r[39:0], bus.dq_in}; crc_r <= crc8_byte(crc_r, bus.dq_in); end
        CA_CRC: crc_r <= 8'h00;
        WDATA:  if (!bus.cs_n) begin wdata_sh_r <= {wdata_sh_r[55:0], bus.dq_in}; crc_r <= crc8_byte(crc_r, bus.dq_in); end
        default: begin end
      endcase
    end
  end

  // Registered outputs, latched memory address/data and saturating NACK counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      dq_out_r <= 8'h00; dq_oe_r <= 1'b0; wr_en_r <= 1'b0; rd_en_r <= 1'b0; done_r <= 1'b0;
      ca_match_r <= 1'b0; ca_error_r <= 1'b0; d_match_r <= 1'b0; d_error_r <= 1'b0;
      mem_addr_r <= 48'h0; mem_wdata_r <= 64'h0; nack_count_r <= 8'h00;
    end else begin
      dq_out_r <= dq_out_s; dq_oe_r <= dq_oe_s; wr_en_r <= wr_en_s; rd_en_r <= rd_en_s;
      done_r <= done_s; ca_match_r <= ca_match_s; ca_error_r <= ca_error_s;
      d_match_r <= d_match_s; d_error_r <= d_error_s;
      if (latch_addr_s) mem_addr_r <= addr_sh_r;
      if (latch_wdata_s) mem_wdata_r <= wdata_sh_r;
      if (nack_inc_s && nack_count_r != 8'hFF) nack_count_r <= nack_count_r + 8'd1;
    end
  end

  assign bus.dq_out         = dq_out_r;
  assign bus.dq_oe          = dq_oe_r;
  assign bus.mem_addr       = mem_addr_r;
  assign bus.mem_wdata      = mem_wdata_r;
  assign bus.mem_wr_en      = wr_en_r;
  assign bus.mem_rd_en      = rd_en_r;
  assign bus.done           = done_r;
  assign bus.crc_ca_match   = ca_match_r;
  assign bus.crc_ca_error   = ca_error_r;
  assign bus.crc_data_match = d_match_r;
  assign bus.crc_data_error = d_error_r;
  assign bus.nack_count     = nack_count_r;
endmodule
